macro_bus_ctrl: RTL and testbench

Wishbone address decoder and pad-ownership controller between the Caravel user-area Wishbone slave port and NUM_MACROS user macros (golden, decap, …) instantiated side by side in the user wrapper. It forwards each host access to exactly one macro, using a timeout so that a dead macro cannot hang the management core. It returns a single registered ack and data word. It also owns a control register that selects which macro drives the io_out/io_oeb pads, so no two macros ever contend on the wrapper outputs.

---
 rtl/macro_bus_pkg.sv | 42 ++++
 rtl/macro_bus_ctrl_if.sv | 21 ++
 rtl/macro_bus_ctrl_io_owner_mux.sv | 31 +++
 rtl/macro_bus_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_macro_bus_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/macro_bus_pkg.sv
// Shared types and constants for the user-area Wishbone decoder.
package macro_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DEC_MACRO    = 2'd0,
        DEC_LOCAL    = 2'd1,
        DEC_UNMAPPED = 2'd2
    } dec_kind_t;

    typedef struct packed {
        dec_kind_t  kind;
        logic [3:0] idx;
    } dec_t;

    localparam logic [7:0]  USER_BASE   = 8'h30;
    localparam logic [3:0]  LOCAL_SEL   = 4'hF;
    localparam logic [19:0] CTRL_OFS    = 20'h0_0000;
    localparam logic [19:0] STATUS_OFS  = 20'h0_0004;
    localparam logic [27:0] TIMEOUT_TAG = 28'hBAD0_000;

    // Classify a host address: macro slot, local register block or unmapped.
    function automatic dec_t decode_addr(input logic [31:0] adr, input int unsigned num_macros);
        dec_t d;
        d.kind = DEC_UNMAPPED;
        d.idx  = adr[23:20];
        if (adr[31:24] == USER_BASE) begin
            if (adr[23:20] == LOCAL_SEL) begin
                d.kind = DEC_LOCAL;
            end else if (32'(adr[23:20]) < num_macros) begin
                d.kind = DEC_MACRO;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/macro_bus_ctrl_if.sv
// Host-side Wishbone classic port of the user area.
interface macro_bus_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/macro_bus_ctrl_io_owner_mux.sv
// Pad ownership mux: exactly one macro (or nobody) drives the wrapper pads.
// When not enabled, or the owner index names no macro, pads fall back to
// inputs with io_out low so nothing can contend.
module io_owner_mux #(
    parameter int unsigned NUM_MACROS = 2,
    parameter int unsigned IO_PADS    = 38
) (
    input  logic [3:0]                    owner,
    input  logic                          io_en,
    input  logic                          io_active,
    input  logic [IO_PADS*NUM_MACROS-1:0] m_io_out_i,
    input  logic [IO_PADS*NUM_MACROS-1:0] m_io_oeb_i,
    output logic [IO_PADS-1:0]            io_out,
    output logic [IO_PADS-1:0]            io_oeb
);

    // Select the owner's slices; an owner index with no matching macro keeps the safe default.
    always_comb begin
        io_out = '0;
        io_oeb = '1;
        if (io_en && io_active) begin
            for (int i = 0; i < int'(NUM_MACROS); i++) begin
                if (owner == 4'(i)) begin
                    io_out = m_io_out_i[IO_PADS*i +: IO_PADS];
                    io_oeb = m_io_oeb_i[IO_PADS*i +: IO_PADS];
                end
            end
        end
    end

endmodule

// File: rtl/macro_bus_ctrl.sv
// Wishbone decoder between the user-area slave port and the attached macros.
// Forwards each access to one macro with a timeout, answers the local
// CTRL/STATUS registers, and owns the pad-ownership control.
module macro_bus_ctrl
    import macro_bus_pkg::*;
#(
    parameter int unsigned NUM_MACROS = 2,
    parameter int unsigned IO_PADS    = 38,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    macro_bus_ctrl_if.slave               wbs,
    input  logic                          io_active,
    output logic [NUM_MACROS-1:0]         m_cyc_o,
    output logic [NUM_MACROS-1:0]         m_stb_o,
    output logic                          m_we_o,
    output logic [3:0]                    m_sel_o,
    output logic [31:0]                   m_adr_o,
    output logic [31:0]                   m_dat_o,
    input  logic [NUM_MACROS-1:0]         m_ack_i,
    input  logic [32*NUM_MACROS-1:0]      m_dat_i,
    input  logic [IO_PADS*NUM_MACROS-1:0] m_io_out_i,
    input  logic [IO_PADS*NUM_MACROS-1:0] m_io_oeb_i,
    output logic [IO_PADS-1:0]            io_out,
    output logic [IO_PADS-1:0]            io_oeb,
    output logic                          irq_o
);

    state_t        state_q, state_n;
    logic [3:0]    idx_q, idx_n;
    logic [15:0]   cnt_q, cnt_n;
    logic          ack_q, ack_n;
    logic [31:0]   dat_q, dat_n;
    logic          local_q, local_n;
    logic [3:0]    owner_q, owner_n;
    logic          io_en_q, io_en_n;
    logic          irq_en_q, irq_en_n;
    logic          sticky_q, sticky_n;
    logic [3:0]    last_q, last_n;
    logic [15:0]   tcnt_q, tcnt_n;
    logic          irq_q, irq_n;

    dec_t                  dec;
    logic                  host_req;
    logic                  timeout_hit;
    logic                  sel_ack;
    logic [31:0]           sel_dat;
    logic [31:0]           local_rd;
    logic [NUM_MACROS-1:0] fwd_sel;

    assign dec      = decode_addr(wbs.wbs_adr_i, NUM_MACROS);
    assign host_req = wbs.wbs_cyc_i & wbs.wbs_stb_i;

    assign m_we_o  = wbs.wbs_we_i;
    assign m_sel_o = wbs.wbs_sel_i;
    assign m_adr_o = wbs.wbs_adr_i;
    assign m_dat_o = wbs.wbs_dat_i;
    assign m_cyc_o = fwd_sel;
    assign m_stb_o = fwd_sel;

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign irq_o         = irq_q;

    // One-hot strobe toward the latched macro while forwarding, plus its ack/data.
    always_comb begin
        fwd_sel = '0;
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < int'(NUM_MACROS); i++) begin
            if (idx_q == 4'(i)) begin
                fwd_sel[i] = (state_q == FWD);
                sel_ack    = m_ack_i[i];
                sel_dat    = m_dat_i[32*i +: 32];
            end
        end
    end

    // Local register read view; offsets other than CTRL/STATUS read as zero.
    always_comb begin
        local_rd = '0;
        if (wbs.wbs_adr_i[19:0] == CTRL_OFS) begin
            local_rd = {22'd0, irq_en_q, io_en_q, 4'd0, owner_q};
        end else if (wbs.wbs_adr_i[19:0] == STATUS_OFS) begin
            local_rd = {tcnt_q, 8'd0, last_q, 3'd0, sticky_q};
        end
    end

    // Next-state and next-register logic; a timeout set overrides a same-cycle sticky clear.
    always_comb begin
        state_n     = state_q;
        idx_n       = idx_q;
        cnt_n       = cnt_q;
        ack_n       = 1'b0;
        dat_n       = dat_q;
        local_n     = local_q;
        owner_n     = owner_q;
        io_en_n     = io_en_q;
        irq_en_n    = irq_en_q;
        sticky_n    = sticky_q;
        last_n      = last_q;
        tcnt_n      = tcnt_q;
        timeout_hit = 1'b0;

        case (state_q)
            IDLE: begin
                if (host_req) begin
                    if (dec.kind == DEC_MACRO) begin
                        state_n = FWD;
                        idx_n   = dec.idx;
                        cnt_n   = '0;
                        local_n = 1'b0;
                    end else begin
                        state_n = RESP;
                        ack_n   = 1'b1;
                        local_n = (dec.kind == DEC_LOCAL);
                        dat_n   = (dec.kind == DEC_LOCAL) ? local_rd : '0;
                    end
                end
            end
            FWD: begin
                if (!wbs.wbs_cyc_i) begin
                    state_n = IDLE;
                end else if (sel_ack) begin
                    dat_n   = sel_dat;
                    ack_n   = 1'b1;
                    state_n = RESP;
                end else if (cnt_q == 16'(TIMEOUT)) begin
                    dat_n       = {TIMEOUT_TAG, idx_q};
                    ack_n       = 1'b1;
                    state_n     = RESP;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
                if (local_q && host_req && wbs.wbs_we_i) begin
                    if (wbs.wbs_adr_i[19:0] == CTRL_OFS) begin
                        owner_n  = wbs.wbs_dat_i[3:0];
                        io_en_n  = wbs.wbs_dat_i[8];
                        irq_en_n = wbs.wbs_dat_i[9];
                    end else if (wbs.wbs_adr_i[19:0] == STATUS_OFS && wbs.wbs_dat_i[0]) begin
                        sticky_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (timeout_hit) begin
            sticky_n = 1'b1;
            last_n   = idx_q;
            if (tcnt_q != 16'hFFFF) begin
                tcnt_n = tcnt_q + 16'd1;
            end
        end

        irq_n = sticky_n & irq_en_n;
    end

    // State and register update with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            local_q  <= 1'b0;
            owner_q  <= '0;
            io_en_q  <= 1'b0;
            irq_en_q <= 1'b0;
            sticky_q <= 1'b0;
            last_q   <= '0;
            tcnt_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            cnt_q    <= cnt_n;
            ack_q    <= ack_n;
            dat_q    <= dat_n;
            local_q  <= local_n;
            owner_q  <= owner_n;
            io_en_q  <= io_en_n;
            irq_en_q <= irq_en_n;
            sticky_q <= sticky_n;
            last_q   <= last_n;
            tcnt_q   <= tcnt_n;
            irq_q    <= irq_n;
        end
    end

    io_owner_mux #(
        .NUM_MACROS (NUM_MACROS),
        .IO_PADS    (IO_PADS)
    ) u_io_owner_mux (
        .owner      (owner_q),
        .io_en      (io_en_q),
        .io_active  (io_active),
        .m_io_out_i (m_io_out_i),
        .m_io_oeb_i (m_io_oeb_i),
        .io_out     (io_out),
        .io_oeb     (io_oeb)
    );

endmodule

// File: tb/tb_macro_bus_ctrl.sv
// Bench for macro_bus_ctrl: directed scenarios plus a randomized run against
// a transaction-level model of decode, latency, local registers and pads.
module tb_macro_bus_ctrl;

    localparam int NM = 2;
    localparam int NP = 38;
    localparam int TO = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 io_active;
    logic [NM-1:0]        m_cyc_o, m_stb_o;
    logic                 m_we_o;
    logic [3:0]           m_sel_o;
    logic [31:0]          m_adr_o, m_dat_o;
    logic [NM-1:0]        m_ack_i;
    logic [32*NM-1:0]     m_dat_i;
    logic [NP*NM-1:0]     m_io_out_i, m_io_oeb_i;
    logic [NP-1:0]        io_out, io_oeb;
    logic                 irq_o;

    macro_bus_ctrl_if bus ();

    macro_bus_ctrl #(.NUM_MACROS(NM), .IO_PADS(NP), .TIMEOUT(TO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs        (bus.slave),
        .io_active  (io_active),
        .m_cyc_o    (m_cyc_o),
        .m_stb_o    (m_stb_o),
        .m_we_o     (m_we_o),
        .m_sel_o    (m_sel_o),
        .m_adr_o    (m_adr_o),
        .m_dat_o    (m_dat_o),
        .m_ack_i    (m_ack_i),
        .m_dat_i    (m_dat_i),
        .m_io_out_i (m_io_out_i),
        .m_io_oeb_i (m_io_oeb_i),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] mdl_ctrl;
    bit          mdl_sticky;
    logic [3:0]  mdl_last;
    int          mdl_count;
    logic [31:0] ref_mem [logic [35:0]];
    // Storage behind the bench's macro responders
    logic [31:0] mac_mem [logic [35:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        mdl_ctrl   = '0;
        mdl_sticky = 1'b0;
        mdl_last   = '0;
        mdl_count  = 0;
    endfunction

    function automatic logic [31:0] model_status();
        return 32'(mdl_count) * 32'd65536 + 32'(mdl_last) * 32'd16 + 32'(mdl_sticky);
    endfunction

    function automatic bit model_irq();
        return mdl_sticky && mdl_ctrl[9];
    endfunction

    function automatic void model_pads(output logic [NP-1:0] eo, output logic [NP-1:0] eb);
        int own;
        own = int'(mdl_ctrl[3:0]);
        eo = '0;
        eb = '1;
        if (mdl_ctrl[8] && io_active && own < NM) begin
            eo = m_io_out_i[own*NP +: NP];
            eb = m_io_oeb_i[own*NP +: NP];
        end
    endfunction

    // d: cycles of strobe before the macro acks (ack in cycle d+1), -1 = never.
    function automatic void model_access(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                                         input int d, output int e_cyc, output logic [31:0] e_dat,
                                         output int e_tgt);
        int field;
        logic [35:0] key;
        field = int'(adr[23:20]);
        e_tgt = -1;
        e_dat = '0;
        e_cyc = 1;
        if (adr[31:24] == 8'h30 && field < NM) begin
            e_tgt = field;
            key   = {adr[23:20], adr};
            if (d >= 0 && d <= TO) begin
                e_cyc = d + 2;
                e_dat = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
                if (we) ref_mem[key] = wd;
            end else begin
                e_cyc      = TO + 2;
                e_dat      = 32'hBAD0_0000 + 32'(field);
                mdl_sticky = 1'b1;
                mdl_last   = adr[23:20];
                if (mdl_count < 65535) mdl_count++;
            end
        end else if (adr[31:24] == 8'h30 && field == 15) begin
            if (adr[19:0] == 20'h0) e_dat = mdl_ctrl;
            else if (adr[19:0] == 20'h4) e_dat = model_status();
            if (we) begin
                if (adr[19:0] == 20'h0) mdl_ctrl = wd & 32'h0000_030F;
                else if (adr[19:0] == 20'h4 && wd[0]) mdl_sticky = 1'b0;
            end
        end
    endfunction

    // Drives one host access and plays the addressed macro; bounded wait for ack.
    task automatic bus_access(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                              input int d, input int tgt, output int ack_cyc, output logic [31:0] rdat,
                              output logic [NM-1:0] stb_c1, output int stb_cycles);
        logic [35:0] key;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = 4'($urandom_range(0, 15));
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wd;
        ack_cyc    = -1;
        rdat       = '0;
        stb_c1     = '0;
        stb_cycles = 0;
        for (int c = 1; c <= TO + 6; c++) begin
            @(posedge clk);
            #1;
            m_ack_i = '0;
            if (c == 1) stb_c1 = m_stb_o;
            if (m_stb_o != '0) stb_cycles++;
            if (bus.wbs_ack_o) begin
                ack_cyc = c;
                rdat    = bus.wbs_dat_o;
                break;
            end
            if (tgt >= 0 && d >= 0 && c == d + 1 && m_stb_o[tgt]) begin
                key = {4'(tgt), m_adr_o};
                m_dat_i = {$urandom, $urandom};
                m_dat_i[32*tgt +: 32] = mac_mem.exists(key) ? mac_mem[key] : 32'h0;
                if (m_we_o) mac_mem[key] = m_dat_o;
                m_ack_i[tgt] = 1'b1;
            end
        end
        if (ack_cyc > 0) tick();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        m_ack_i       = '0;
    endtask

    task automatic run_access(input logic [31:0] adr, input logic we, input logic [31:0] wd, input int d,
                              output int e_cyc, output int a_cyc, output logic [31:0] e_dat,
                              output logic [31:0] a_dat, output logic [NM-1:0] e_s1,
                              output logic [NM-1:0] a_s1, output int e_sc, output int a_sc);
        int tgt;
        model_access(adr, we, wd, d, e_cyc, e_dat, tgt);
        e_s1 = '0;
        if (tgt >= 0) e_s1[tgt] = 1'b1;
        e_sc = (tgt >= 0) ? e_cyc - 1 : 0;
        bus_access(adr, we, wd, d, tgt, a_cyc, a_dat, a_s1, a_sc);
    endtask

    task automatic test_reset();
        int ec, ac, es, asc;
        logic [31:0] ed, ad;
        logic [NM-1:0] e1, a1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        tick();
        n_cmp++; if (bus.wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", bus.wbs_ack_o); end
        n_cmp++; if (bus.wbs_dat_o !== 32'h0) begin n_bad++; $display("FAIL reset_dat: got %h expected 0", bus.wbs_dat_o); end
        n_cmp++; if (m_stb_o !== '0 || m_cyc_o !== '0) begin n_bad++; $display("FAIL reset_strobe: got stb=%b cyc=%b expected 0", m_stb_o, m_cyc_o); end
        n_cmp++; if (io_oeb !== 38'h3F_FFFF_FFFF || io_out !== '0) begin n_bad++; $display("FAIL reset_pads: got oeb=%h out=%h expected 3fffffffff/0", io_oeb, io_out); end
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
        run_access(32'h30F0_0000, 1'b0, 32'h0, 0, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ac !== 1) begin n_bad++; $display("FAIL reset_ctrl_latency: got %0d expected 1", ac); end
        n_cmp++; if (ad !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl_data: got %h expected 0", ad); end
    endtask

    task automatic test_forward();
        int ec, ac, es, asc;
        logic [31:0] ed, ad;
        logic [NM-1:0] e1, a1;
        run_access(32'h3010_0008, 1'b1, 32'hA5A5_5A5A, 3, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ac !== 5) begin n_bad++; $display("FAIL fwd_wr_latency: got %0d expected 5", ac); end
        n_cmp++; if (a1 !== 2'b10) begin n_bad++; $display("FAIL fwd_wr_strobe: got %b expected 10", a1); end
        n_cmp++; if (asc !== es) begin n_bad++; $display("FAIL fwd_wr_strobe_len: got %0d expected %0d", asc, es); end
        run_access(32'h3000_0008, 1'b1, 32'h1234_5678, 0, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (a1 !== 2'b01 || ac !== 2) begin n_bad++; $display("FAIL fwd_m0_wr: got stb=%b lat=%0d expected 01/2", a1, ac); end
        run_access(32'h3010_0008, 1'b0, 32'h0, 1, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ad !== 32'hA5A5_5A5A || ac !== 3) begin n_bad++; $display("FAIL fwd_readback: got %h lat=%0d expected a5a55a5a/3", ad, ac); end
        run_access(32'h3000_0008, 1'b0, 32'h0, 2, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ad !== 32'h1234_5678) begin n_bad++; $display("FAIL fwd_m0_readback: got %h expected 12345678", ad); end
    endtask

    task automatic test_timeout();
        int ec, ac, es, asc;
        logic [31:0] ed, ad;
        logic [NM-1:0] e1, a1;
        run_access(32'h30F0_0000, 1'b1, 32'h0000_0200, 0, ec, ac, ed, ad, e1, a1, es, asc);
        run_access(32'h3000_0010, 1'b0, 32'h0, -1, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ac !== TO + 2) begin n_bad++; $display("FAIL to_latency: got %0d expected %0d", ac, TO + 2); end
        n_cmp++; if (ad !== 32'hBAD0_0000) begin n_bad++; $display("FAIL to_data: got %h expected bad00000", ad); end
        n_cmp++; if (asc !== TO + 1) begin n_bad++; $display("FAIL to_strobe_len: got %0d expected %0d", asc, TO + 1); end
        n_cmp++; if (irq_o !== 1'b1) begin n_bad++; $display("FAIL to_irq_set: got %b expected 1", irq_o); end
        run_access(32'h30F0_0004, 1'b0, 32'h0, 0, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ad !== 32'h0001_0001) begin n_bad++; $display("FAIL to_status: got %h expected 00010001", ad); end
        run_access(32'h30F0_0004, 1'b1, 32'h0000_0001, 0, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL to_irq_w1c: got %b expected 0", irq_o); end
        run_access(32'h3000_0020, 1'b0, 32'h0, TO, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ad !== ed || ac !== TO + 2) begin n_bad++; $display("FAIL to_ack_wins: got %h lat=%0d expected %h/%0d", ad, ac, ed, TO + 2); end
        run_access(32'h3010_0020, 1'b0, 32'h0, TO + 1, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ad !== 32'hBAD0_0001) begin n_bad++; $display("FAIL to_m1_data: got %h expected bad00001", ad); end
        run_access(32'h30F0_0004, 1'b0, 32'h0, 0, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ad !== 32'h0002_0011) begin n_bad++; $display("FAIL to_status2: got %h expected 00020011", ad); end
    endtask

    task automatic test_pads();
        int ec, ac, es, asc;
        logic [31:0] ed, ad;
        logic [NM-1:0] e1, a1;
        for (int b = 0; b < NP*NM; b++) begin
            m_io_out_i[b] = 1'($urandom_range(0, 1));
            m_io_oeb_i[b] = 1'($urandom_range(0, 1));
        end
        io_active = 1'b1;
        run_access(32'h30F0_0000, 1'b1, 32'h0000_0101, 0, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (io_out !== m_io_out_i[NP +: NP] || io_oeb !== m_io_oeb_i[NP +: NP]) begin
            n_bad++; $display("FAIL pads_owner1: got out=%h oeb=%h expected %h/%h", io_out, io_oeb, m_io_out_i[NP +: NP], m_io_oeb_i[NP +: NP]); end
        io_active = 1'b0;
        #1;
        n_cmp++; if (io_oeb !== '1 || io_out !== '0) begin n_bad++; $display("FAIL pads_inactive: got out=%h oeb=%h expected 0/all-ones", io_out, io_oeb); end
    endtask

    task automatic test_owner_unmapped();
        int ec, ac, es, asc;
        logic [31:0] ed, ad;
        logic [NM-1:0] e1, a1;
        io_active = 1'b1;
        run_access(32'h30F0_0000, 1'b1, 32'h0000_0105, 0, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (io_oeb !== '1 || io_out !== '0) begin n_bad++; $display("FAIL owner5_safe: got out=%h oeb=%h expected 0/all-ones", io_out, io_oeb); end
        run_access(32'h30F0_0000, 1'b0, 32'h0, 0, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ad !== 32'h0000_0105) begin n_bad++; $display("FAIL ctrl_readback: got %h expected 00000105", ad); end
        run_access(32'h3050_0000, 1'b0, 32'h0, 0, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ac !== 1 || ad !== 32'h0 || asc !== 0) begin n_bad++; $display("FAIL unmapped: got lat=%0d data=%h stb=%0d expected 1/0/0", ac, ad, asc); end
        run_access(32'h2010_0000, 1'b0, 32'h0, 0, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ac !== 1 || ad !== 32'h0 || asc !== 0) begin n_bad++; $display("FAIL other_base: got lat=%0d data=%h stb=%0d expected 1/0/0", ac, ad, asc); end
    endtask

    task automatic test_abort();
        int ec, ac, es, asc;
        logic [31:0] ed, ad;
        logic [NM-1:0] e1, a1;
        bit seen_ack;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = 32'h3010_0040;
        repeat (3) tick();
        n_cmp++; if (m_stb_o !== 2'b10) begin n_bad++; $display("FAIL abort_pre_stb: got %b expected 10", m_stb_o); end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        tick();
        n_cmp++; if (m_stb_o !== '0 || m_cyc_o !== '0) begin n_bad++; $display("FAIL abort_stb_drop: got stb=%b cyc=%b expected 0", m_stb_o, m_cyc_o); end
        seen_ack = 1'b0;
        for (int c = 0; c < TO + 4; c++) begin
            if (bus.wbs_ack_o) seen_ack = 1'b1;
            tick();
        end
        n_cmp++; if (seen_ack !== 1'b0) begin n_bad++; $display("FAIL abort_no_ack: got %b expected 0", seen_ack); end
        run_access(32'h3000_0008, 1'b0, 32'h0, 2, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ac !== 4 || ad !== 32'h1234_5678) begin n_bad++; $display("FAIL abort_next: got lat=%0d data=%h expected 4/12345678", ac, ad); end

        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        bus.wbs_adr_i = 32'h3000_0040;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (m_stb_o !== '0 || bus.wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_fwd: got stb=%b ack=%b expected 0/0", m_stb_o, bus.wbs_ack_o); end
        rst = 1'b0;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        model_reset();
        seen_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.wbs_ack_o) seen_ack = 1'b1;
        end
        n_cmp++; if (seen_ack !== 1'b0) begin n_bad++; $display("FAIL rst_no_ack: got %b expected 0", seen_ack); end
        run_access(32'h30F0_0004, 1'b0, 32'h0, 0, ec, ac, ed, ad, e1, a1, es, asc);
        n_cmp++; if (ac !== 1 || ad !== 32'h0) begin n_bad++; $display("FAIL rst_status: got lat=%0d data=%h expected 1/0", ac, ad); end
    endtask

    task automatic test_random();
        int ec, ac, es, asc, kind, d;
        logic [31:0] ed, ad, adr, wd;
        logic [NM-1:0] e1, a1;
        logic [NP-1:0] eo, eb;
        logic [3:0] f;
        logic [19:0] off;
        logic we;
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 4));
            off  = 20'($urandom_range(0, 255)) << 2;
            case (kind)
                0, 1: f = 4'($urandom_range(0, NM - 1));
                2: begin f = 4'hF; off = 20'($urandom_range(0, 2)) << 2; end
                default: f = 4'($urandom_range(NM, 14));
            endcase
            adr = {(kind == 4) ? 8'h31 : 8'h30, f, off};
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            d   = int'($urandom_range(0, TO + 3));
            io_active = 1'($urandom_range(0, 1));
            if (it % 8 == 0) begin
                for (int b = 0; b < NP*NM; b++) begin
                    m_io_out_i[b] = 1'($urandom_range(0, 1));
                    m_io_oeb_i[b] = 1'($urandom_range(0, 1));
                end
            end
            run_access(adr, we, wd, d, ec, ac, ed, ad, e1, a1, es, asc);
            n_cmp++; if (ac !== ec) begin n_bad++; $display("FAIL rnd_latency[%0d] adr=%h: got %0d expected %0d", it, adr, ac, ec); end
            n_cmp++; if (a1 !== e1 || asc !== es) begin n_bad++; $display("FAIL rnd_strobe[%0d] adr=%h: got %b/%0d expected %b/%0d", it, adr, a1, asc, e1, es); end
            if (!we || ed[31:4] == 28'hBAD0_000) begin
                n_cmp++; if (ad !== ed) begin n_bad++; $display("FAIL rnd_data[%0d] adr=%h: got %h expected %h", it, adr, ad, ed); end
            end
            n_cmp++; if (irq_o !== model_irq()) begin n_bad++; $display("FAIL rnd_irq[%0d]: got %b expected %b", it, irq_o, model_irq()); end
            model_pads(eo, eb);
            n_cmp++; if (io_out !== eo || io_oeb !== eb) begin n_bad++; $display("FAIL rnd_pads[%0d]: got %h/%h expected %h/%h", it, io_out, io_oeb, eo, eb); end
        end
    endtask

    initial begin
        rst = 1'b1;
        io_active = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        m_ack_i    = '0;
        m_dat_i    = '0;
        m_io_out_i = '0;
        m_io_oeb_i = '0;
        model_reset();
        test_reset();
        test_forward();
        test_timeout();
        test_pads();
        test_owner_unmapped();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
